// File: rtl/dlx_mem_pkg.sv
// rtl/dlx_mem_pkg.sv - shared sizes, states and lane constants for the data-memory bridge
package dlx_mem_pkg;

    // Width of one byte lane on the word-wide bus
    localparam int LANE_W = 8;

    // Access size encodings as presented on MemSize (2'b11 behaves as word)
    localparam logic [0:1] SIZE_BYTE = 2'b00;
    localparam logic [0:1] SIZE_HALF = 2'b01;
    localparam logic [0:1] SIZE_WORD = 2'b10;

    // Byte enables, bit 0 is the most significant lane
    localparam logic [0:3] BE_NONE    = 4'b0000;
    localparam logic [0:3] BE_LANE0   = 4'b1000;
    localparam logic [0:3] BE_HALF_HI = 4'b1100;
    localparam logic [0:3] BE_HALF_LO = 4'b0011;
    localparam logic [0:3] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Pick one big-endian byte lane out of a bus word
    function automatic logic [0:7] lane_byte(input logic [0:31] word, input logic [0:1] lane);
        logic [0:7] b;
        case (lane)
            2'd0:    b = word[0:7];
            2'd1:    b = word[8:15];
            2'd2:    b = word[16:23];
            default: b = word[24:31];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane replication, byte enables, load extraction and misalignment check
module dmem_lane_align
    import dlx_mem_pkg::*;
(
    input  logic [0:1]  offset,
    input  logic [0:1]  size,
    input  logic [0:31] wdata,
    output logic [0:3]  be,
    output logic [0:31] bus_wdata,
    output logic        misaligned,
    input  logic [0:1]  rd_offset,
    input  logic [0:1]  rd_size,
    input  logic        rd_ext,
    input  logic [0:31] rdata,
    output logic [0:31] load_data
);

    logic [0:7]  lane_b;
    logic [0:15] half_h;

    // Request side: enables follow the size for loads and stores alike; store data is replicated to every lane
    always_comb begin
        be         = BE_NONE;
        bus_wdata  = wdata;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be        = BE_LANE0 >> offset;
                bus_wdata = {4{wdata[24:31]}};
            end
            SIZE_HALF: begin
                be         = offset[0] ? BE_HALF_LO : BE_HALF_HI;
                bus_wdata  = {2{wdata[16:31]}};
                misaligned = offset[1];
            end
            SIZE_WORD, 2'b11: begin
                be         = BE_WORD;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

    // Response side: right-justify the addressed lanes of the read word and extend them
    always_comb begin
        lane_b    = lane_byte(rdata, rd_offset);
        half_h    = rd_offset[0] ? rdata[16:31] : rdata[0:15];
        load_data = rdata;
        case (rd_size)
            SIZE_BYTE:        load_data = {{(32 - LANE_W){rd_ext & lane_b[0]}}, lane_b};
            SIZE_HALF:        load_data = {{(32 - 2 * LANE_W){rd_ext & half_h[0]}}, half_h};
            SIZE_WORD, 2'b11: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - memory-stage to req/ack data SRAM bridge with stall, alignment and timeout
module dmem_bridge
    import dlx_mem_pkg::*;
#(
    parameter int TimeoutCycles = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] MemAddr,
    input  logic [0:31] MemWData,
    input  logic        MemWE,
    input  logic        MemRE,
    input  logic [0:1]  MemSize,
    input  logic        MemExt,
    output logic [0:31] DMEM_Dout,
    output logic        Stall,
    output logic        Fault,
    output logic        BusReq,
    output logic        BusWE,
    output logic [0:29] BusAddr,
    output logic [0:3]  BusBE,
    output logic [0:31] BusWData,
    input  logic        BusAck,
    input  logic [0:31] BusRData
);

    localparam logic [7:0] CNT_LAST = 8'(TimeoutCycles - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic        mem_req;
    logic        start;
    logic        acked;
    logic        timed_out;
    logic        mis;
    logic [0:3]  be;
    logic [0:31] st_wdata;
    logic [0:31] ld_data;
    logic        req_we;
    logic [0:1]  req_off;
    logic [0:1]  req_size;
    logic        req_ext;

    assign mem_req = MemWE | MemRE;

    dmem_lane_align u_align (
        .offset     (MemAddr[30:31]),
        .size       (MemSize),
        .wdata      (MemWData),
        .be         (be),
        .bus_wdata  (st_wdata),
        .misaligned (mis),
        .rd_offset  (req_off),
        .rd_size    (req_size),
        .rd_ext     (req_ext),
        .rdata      (BusRData),
        .load_data  (ld_data)
    );

    // Next state and stall; the stall in IDLE is gated by reset so an aborting reset freezes nothing
    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        start      = 1'b0;
        acked      = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !mis) begin
                    start      = 1'b1;
                    Stall      = reset;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                if (BusAck) begin
                    acked      = 1'b1;
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ACCESS cycle counter, restarted whenever a new transaction is launched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (start) begin
            cnt <= 8'd0;
        end else if (state == ACCESS) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Bus request and request context, captured once so the bus stays stable while BusReq is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BusReq   <= 1'b0;
            BusWE    <= 1'b0;
            BusAddr  <= '0;
            BusBE    <= '0;
            BusWData <= '0;
            req_we   <= 1'b0;
            req_off  <= '0;
            req_size <= '0;
            req_ext  <= 1'b0;
        end else if (start) begin
            BusReq   <= 1'b1;
            BusWE    <= MemWE;
            BusAddr  <= MemAddr[0:29];
            BusBE    <= be;
            BusWData <= st_wdata;
            req_we   <= MemWE;
            req_off  <= MemAddr[30:31];
            req_size <= MemSize;
            req_ext  <= MemExt;
        end else if (acked || timed_out) begin
            BusReq <= 1'b0;
            BusWE  <= 1'b0;
        end
    end

    // Load result and fault pulse; a timeout clears the result so a stale value is never consumed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DMEM_Dout <= '0;
            Fault     <= 1'b0;
        end else begin
            Fault <= ((state == IDLE) && mem_req && mis) || timed_out;
            if (acked && !req_we) begin
                DMEM_Dout <= ld_data;
            end else if (timed_out) begin
                DMEM_Dout <= '0;
            end
        end
    end

endmodule
